dma_w_burst_ctrl: RTL and testbench

- Transfer sequencer in front of the AXI-4 DMA write engine: takes one job (base address, word count) plus a source data stream.
- Splits the job into AXI bursts no longer than MAX_BURST beats that never cross a 4 KB boundary.
- Programs the engine per burst (address, dma_len), forwards data beats, collects per-burst write errors, and reports job completion.

---
 rtl/dma_w_burst_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dma_w_burst_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_w_burst_ctrl.sv
// dma_w_burst_ctrl: splits one write job into AXI bursts for the DMA write engine.
// Each burst is at most MAX_BURST beats and never crosses a 4 KB boundary.
// For every burst the controller programs the engine, forwards the data beats,
// and collects the write response.
// Optional build macro DMA_W_BURST_CTRL_STOP_ON_ERR_EN: when defined, the first
// error response ends the job early.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no job; cfg_* sampled on cfg_start
// CALC      | size next burst, register eng_addr / eng_dma_len
// WAIT_ENG  | wait for engine idle before presenting the burst
// STREAM    | forward source beats to the engine
// WAIT_RESP | wait for burst response, advance address / remaining count
module dma_w_burst_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int TOTAL_W   = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [TOTAL_W-1:0]  cfg_words,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_strb,
  output logic                eng_valid,
  input  logic                eng_ready,
  output logic [ADDR_W-1:0]   eng_addr,
  output logic [LEN_W-1:0]    eng_dma_len,
  output logic [DATA_W-1:0]   eng_wdata,
  output logic [DATA_W/8-1:0] eng_wstrb,
  input  logic                eng_dma_ready,
  input  logic                eng_error
);

  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int BW    = LEN_W + 1;
  // Wide enough for both the job count and the 4 KB room (up to 4096).
  localparam int CW    = (TOTAL_W > 13) ? TOTAL_W : 13;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CALC      = 3'd1;
  localparam logic [2:0] S_WAIT_ENG  = 3'd2;
  localparam logic [2:0] S_STREAM    = 3'd3;
  localparam logic [2:0] S_WAIT_RESP = 3'd4;

  logic [2:0]         r_state;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic [TOTAL_W-1:0] r_remaining;
  logic [BW-1:0]      r_beats;
  logic [BW-1:0]      r_beat_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [ADDR_W-1:0]  r_eng_addr;
  logic [LEN_W-1:0]   r_eng_len;

  logic [12:0]        w_room;
  logic [CW-1:0]      w_min;
  logic [BW-1:0]      w_beats;
  logic               w_xfer;
  logic               w_last;
  logic [TOTAL_W-1:0] w_rem_next;
  logic [ADDR_W-1:0]  w_addr_next;
  logic               w_finish;

  // Beats that fit before the next 4 KB boundary (cur_addr is beat aligned, so >= 1).
  assign w_room = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> BSH;

  // Burst size = min(remaining, MAX_BURST, room to 4 KB boundary).
  always_comb begin
    w_min = CW'(r_remaining);
    if (CW'(MAX_BURST) < w_min) w_min = CW'(MAX_BURST);
    if (CW'(w_room) < w_min)    w_min = CW'(w_room);
    w_beats = BW'(w_min);
  end

  assign w_xfer      = (r_state == S_STREAM) && s_valid && eng_ready;
  assign w_last      = (r_beat_cnt == (r_beats - BW'(1)));
  assign w_rem_next  = r_remaining - TOTAL_W'(r_beats);
  assign w_addr_next = r_cur_addr + (ADDR_W'(r_beats) << BSH);

`ifdef DMA_W_BURST_CTRL_STOP_ON_ERR_EN
  assign w_finish = (w_rem_next == '0) || eng_error;
`else
  assign w_finish = (w_rem_next == '0);
`endif

  // Handshakes are passed straight through only while streaming a burst.
  assign eng_valid   = (r_state == S_STREAM) && s_valid;
  assign s_ready     = (r_state == S_STREAM) && eng_ready;
  assign eng_wdata   = s_data;
  assign eng_wstrb   = s_strb;
  assign eng_addr    = r_eng_addr;
  assign eng_dma_len = r_eng_len;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

  // Job sequencer: burst sizing, beat counting and response collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_beat_cnt  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_eng_addr  <= '0;
      r_eng_len   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_cur_addr  <= cfg_addr & ~ADDR_W'(BYTES - 1);
            r_remaining <= cfg_words;
            r_err       <= 1'b0;
            if (cfg_words == '0) begin
              // Empty job: report completion without touching the engine.
              r_done <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_beats    <= w_beats;
          r_eng_addr <= r_cur_addr;
          r_eng_len  <= LEN_W'(w_beats - BW'(1));
          r_beat_cnt <= '0;
          r_state    <= S_WAIT_ENG;
        end
        S_WAIT_ENG: begin
          if (eng_dma_ready) r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (w_last) r_state <= S_WAIT_RESP;
            else        r_beat_cnt <= r_beat_cnt + BW'(1);
          end
        end
        S_WAIT_RESP: begin
          if (eng_dma_ready) begin
            r_err       <= r_err | eng_error;
            r_cur_addr  <= w_addr_next;
            r_remaining <= w_rem_next;
            if (w_finish) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_w_burst_ctrl.sv
// Directed bench for dma_w_burst_ctrl with a small engine model and source model.
module tb_dma_w_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [15:0] cfg_words = '0;
  logic        busy, done, err;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_strb;
  logic        eng_valid, eng_ready;
  logic [31:0] eng_addr;
  logic [7:0]  eng_dma_len;
  logic [31:0] eng_wdata;
  logic [3:0]  eng_wstrb;
  logic        eng_dma_ready, eng_error;

  always #5 clk = ~clk;

  dma_w_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_words(cfg_words),
    .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb),
    .eng_valid(eng_valid), .eng_ready(eng_ready),
    .eng_addr(eng_addr), .eng_dma_len(eng_dma_len),
    .eng_wdata(eng_wdata), .eng_wstrb(eng_wstrb),
    .eng_dma_ready(eng_dma_ready), .eng_error(eng_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strb_of(input int i);
    return 4'(i) ^ 4'hA;
  endfunction

  // stimulus controls, written only by the main initial block
  int bp_mode   = 0;
  int err_b_abs = -1;
  int src_limit = 0;

  // engine model state
  localparam int E_IDLE = 0, E_DATA = 1, E_RESP = 2;
  int          e_state = E_IDLE;
  int          e_cnt = 0, e_len = 0, e_wait = 0;
  logic        e_err = 1'b0;
  int          b_total = 0, beat_total = 0, data_err = 0, bad_valid = 0;
  int          done_total = 0, v_total = 0;
  logic [31:0] addr_log [64];
  logic [7:0]  len_log  [64];
  int          s_idx = 0;
  int          cyc = 0;

  // engine: address phase on first eng_valid, then len+1 beats, then a delayed response
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_state <= E_IDLE;
      e_cnt   <= 0;
      e_wait  <= 0;
      e_err   <= 1'b0;
    end else begin
      if (done) done_total <= done_total + 1;
      if (eng_valid) v_total <= v_total + 1;
      if (eng_valid && e_state == E_RESP) bad_valid <= bad_valid + 1;
      case (e_state)
        E_IDLE: if (eng_valid) begin
          addr_log[b_total % 64] <= eng_addr;
          len_log[b_total % 64]  <= eng_dma_len;
          e_len   <= int'(eng_dma_len);
          e_cnt   <= 0;
          e_state <= E_DATA;
          b_total <= b_total + 1;
        end
        E_DATA: if (eng_valid && eng_ready) begin
          if (eng_wdata !== 32'hA000_0000 + 32'(beat_total) || eng_wstrb !== strb_of(beat_total))
            data_err <= data_err + 1;
          beat_total <= beat_total + 1;
          if (e_cnt == e_len) begin
            e_state <= E_RESP;
            e_wait  <= 2;
          end else begin
            e_cnt <= e_cnt + 1;
          end
        end
        E_RESP: if (e_wait == 0) begin
          e_state <= E_IDLE;
          e_err   <= ((b_total - 1) == err_b_abs);
        end else begin
          e_wait <= e_wait - 1;
        end
        default: e_state <= E_IDLE;
      endcase
    end
  end

  always @(posedge clk) if (s_valid && s_ready) s_idx <= s_idx + 1;

  // drive engine and source inputs away from the active edge
  always @(negedge clk) begin
    cyc++;
    eng_dma_ready = (e_state == E_IDLE);
    eng_error     = e_err;
    eng_ready     = (e_state == E_DATA) && (bp_mode == 0 || cyc % 4 == 0);
    s_valid       = (s_idx < src_limit) && (bp_mode == 0 || cyc % 2 == 0);
    s_data        = 32'hA000_0000 + 32'(s_idx);
    s_strb        = strb_of(s_idx);
  end

  task automatic start_job(input logic [31:0] a, input logic [15:0] w);
    src_limit = s_idx + int'(w);
    cfg_addr  = a;
    cfg_words = w;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_burst(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
    chk({tag, "_addr"}, 64'(addr_log[idx % 64]), 64'(a));
    chk({tag, "_len"},  64'(len_log[idx % 64]),  64'(l));
  endtask

  int b0, d0, bt0, v0;

  task automatic snap();
    b0 = b_total; d0 = done_total; bt0 = beat_total; v0 = v_total;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, err, eng_valid, s_ready, eng_addr, eng_dma_len}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // three-way split, no stalls
    snap();
    start_job(32'h0, 16'd40);
    wait_done("split", 2000);
    chk("split_bursts", 64'(b_total - b0), 64'd3);
    chk_burst("split_b0", b0,     32'h000, 8'd15);
    chk_burst("split_b1", b0 + 1, 32'h040, 8'd15);
    chk_burst("split_b2", b0 + 2, 32'h080, 8'd7);
    chk("split_beats", 64'(beat_total - bt0), 64'd40);
    chk("split_dones", 64'(done_total - d0), 64'd1);
    chk("split_err",   64'(err), 64'd0);
    chk("split_busy",  64'(busy), 64'd0);

    // 4 KB boundary
    snap();
    start_job(32'hFF0, 16'd8);
    wait_done("b4k", 2000);
    chk("b4k_bursts", 64'(b_total - b0), 64'd2);
    chk_burst("b4k_b0", b0,     32'hFF0,  8'd3);
    chk_burst("b4k_b1", b0 + 1, 32'h1000, 8'd3);
    chk("b4k_beats", 64'(beat_total - bt0), 64'd8);

    // backpressure on both sides
    snap();
    bp_mode = 1;
    start_job(32'h2000, 16'd20);
    wait_done("bp", 4000);
    bp_mode = 0;
    chk("bp_bursts", 64'(b_total - b0), 64'd2);
    chk_burst("bp_b0", b0,     32'h2000, 8'd15);
    chk_burst("bp_b1", b0 + 1, 32'h2040, 8'd3);
    chk("bp_beats", 64'(beat_total - bt0), 64'd20);
    chk("bp_valid_outside_stream", 64'(bad_valid), 64'd0);

    // error response on the second burst
    snap();
    err_b_abs = b_total + 1;
    start_job(32'h0, 16'd40);
    wait_done("errj", 2000);
    err_b_abs = -1;
`ifdef DMA_W_BURST_CTRL_STOP_ON_ERR_EN
    chk("errj_bursts", 64'(b_total - b0), 64'd2);
    chk("errj_beats",  64'(beat_total - bt0), 64'd32);
`else
    chk("errj_bursts", 64'(b_total - b0), 64'd3);
    chk("errj_beats",  64'(beat_total - bt0), 64'd40);
`endif
    chk("errj_err",   64'(err), 64'd1);
    chk("errj_dones", 64'(done_total - d0), 64'd1);

    // next accepted start clears err
    snap();
    start_job(32'h3000, 16'd4);
    chk("errclr_at_start", 64'(err), 64'd0);
    wait_done("errclr", 2000);
    chk("errclr_err", 64'(err), 64'd0);
    chk_burst("errclr_b0", b0, 32'h3000, 8'd3);

    // zero-length job
    snap();
    start_job(32'h10, 16'd0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    chk("zero_valid_cycles", 64'(v_total - v0), 64'd0);
    chk("zero_dones", 64'(done_total - d0), 64'd1);

    // cfg_start while busy is ignored
    snap();
    start_job(32'h100, 16'd8);
    repeat (3) @(negedge clk);
    chk("ign_busy_before", 64'(busy), 64'd1);
    cfg_addr  = 32'h500;
    cfg_words = 16'd3;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done("ign", 2000);
    chk("ign_bursts", 64'(b_total - b0), 64'd1);
    chk_burst("ign_b0", b0, 32'h100, 8'd7);
    chk("ign_dones", 64'(done_total - d0), 64'd1);
    chk("ign_busy_after", 64'(busy), 64'd0);

    // reset in the middle of streaming
    snap();
    start_job(32'h300, 16'd40);
    begin
      int n = 0;
      while (beat_total < bt0 + 5 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_reached_stream", 64'(beat_total >= bt0 + 5), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_outputs", 64'({busy, done, err, eng_valid, s_ready, eng_addr, eng_dma_len}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_done", 64'(done_total - d0), 64'd0);
    snap();
    start_job(32'h400, 16'd8);
    wait_done("post_rst", 2000);
    chk("post_rst_bursts", 64'(b_total - b0), 64'd1);
    chk_burst("post_rst_b0", b0, 32'h400, 8'd7);
    chk("post_rst_beats", 64'(beat_total - bt0), 64'd8);
    chk("post_rst_err", 64'(err), 64'd0);

    chk("data_order", 64'(data_err), 64'd0);
    chk("valid_outside_stream", 64'(bad_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
